seg_display_mux: RTL and testbench

Four-digit, time-multiplexed 7-segment display driver that sits directly downstream of the time-of-day counter. It consumes the HH:MM BCD digits and scans them onto a common-anode display with active-low anode and segment lines. It adds ghost-free blanking between digit slots, tear-free per-frame digit snapshots, leading-zero suppression and a blinking colon.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/seg_display_mux.sv | 124 ++++++++++++
 tb/tb_seg_display_mux.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment/anode constants for the 7-segment display mux
package seg_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD digit to active-low 7-segment pattern, dash for non-BCD codes
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - four-digit multiplexed HH:MM display driver with blanking,
// per-frame snapshot, leading-zero suppression and blinking colon
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500,
  parameter int BLINK_TICKS = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hour1,
  input  logic [3:0] hour0,
  input  logic [2:0] min1,
  input  logic [3:0] min0,
  input  logic       blank_lead,
  input  logic       colon_blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] TICK_SHOW = TW'(BLANK_TICKS);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic [1:0]    idx;
  logic [TW-1:0] tick;
  logic [BW-1:0] blink_cnt;
  logic          colon_on;

  logic [1:0] snap_h1;
  logic [3:0] snap_h0;
  logic [2:0] snap_m1;
  logic [3:0] snap_m0;

  logic       frame_start;
  logic       show;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0;
  logic [2:0] cur_m1;
  logic [3:0] cur_m0;
  logic [3:0] digit;
  logic [6:0] enc;
  logic       lead_off;

  // On the snapshot edge the registers still hold the old frame, so use the
  // live inputs directly; otherwise a zero-length blank would show stale data.
  always_comb begin
    frame_start = (idx == 2'd0) && (tick == '0);
    show        = (tick >= TICK_SHOW);
    cur_h1      = frame_start ? hour1 : snap_h1;
    cur_h0      = frame_start ? hour0 : snap_h0;
    cur_m1      = frame_start ? min1  : snap_m1;
    cur_m0      = frame_start ? min0  : snap_m0;
    digit       = cur_m0;
    case (idx)
      2'd0: digit = cur_m0;
      2'd1: digit = {1'b0, cur_m1};
      2'd2: digit = cur_h0;
      2'd3: digit = {2'b00, cur_h1};
      default: digit = cur_m0;
    endcase
    lead_off = (idx == 2'd3) && blank_lead && (cur_h1 == 2'd0);
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (enc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= 2'd0;
      tick      <= '0;
      blink_cnt <= '0;
      colon_on  <= 1'b1;
      snap_h1   <= '0;
      snap_h0   <= '0;
      snap_m1   <= '0;
      snap_m0   <= '0;
      an        <= AN_OFF;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      if (tick == TICK_MAX) begin
        tick <= '0;
        idx  <= idx + 2'd1;
      end else begin
        tick <= tick + 1'b1;
      end

      if (frame_start) begin
        snap_h1 <= hour1;
        snap_h0 <= hour0;
        snap_m1 <= min1;
        snap_m0 <= min0;
      end

      if (!colon_blink) begin
        blink_cnt <= '0;
        colon_on  <= 1'b1;
      end else if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        colon_on  <= ~colon_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (show) begin
        an  <= ~(4'b0001 << idx);
        seg <= lead_off ? SEG_BLANK : enc;
        dp  <= ~((idx == 2'd2) && colon_on);
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - scoreboard bench for seg_display_mux with small tick parameters
module tb_seg_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] hour1 = '0;
  logic [3:0] hour0 = '0;
  logic [2:0] min1 = '0;
  logic [3:0] min0 = '0;
  logic       blank_lead = 1'b0;
  logic       colon_blink = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg_display_mux #(.DIGIT_TICKS(8), .BLANK_TICKS(2), .BLINK_TICKS(20)) dut (
    .clk(clk), .rst(rst), .hour1(hour1), .hour0(hour0), .min1(min1), .min0(min0),
    .blank_lead(blank_lead), .colon_blink(colon_blink), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_n = 0;
    else      edge_n = edge_n + 1;
  end

  task automatic compare(input string nm, input int e, input logic [3:0] ea,
                         input logic [6:0] es, input logic ed);
    checks++;
    if (an !== ea || seg !== es || dp !== ed) begin
      errors++;
      $display("FAIL %s edge %0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               nm, e, an, seg, dp, ea, es, ed);
    end
  endtask

  // Monitor: compares the DUT against the expected entry for the current edge
  always @(negedge clk) begin
    if (rst) begin
      while (sb.size() > 0 && sb[0].e < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s edge %0d: never compared (now edge %0d)", sb[0].nm, sb[0].e, edge_n);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].e == edge_n) begin
        compare(sb[0].nm, sb[0].e, sb[0].an, sb[0].seg, sb[0].dp);
        void'(sb.pop_front());
      end
    end
  end

  task automatic exp(input string nm, input int e, input logic [3:0] a,
                     input logic [6:0] s, input logic d);
    exp_t x;
    x.e = e; x.an = a; x.seg = s; x.dp = d; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until(input int e);
    int n = 0;
    while (edge_n < e && n < 1000) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (edge_n < e) begin
      checks++;
      errors++;
      $display("FAIL run_until: reached edge %0d, want %0d", edge_n, e);
    end
  endtask

  task automatic drain(input string nm);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d pending, want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b0;
    #2;
  endtask

  initial begin
    // Scenario: 12:34, first frame, snapshot stability, async reset in slot 2
    hour1 = 2'd1; hour0 = 4'd2; min1 = 3'd3; min0 = 4'd4;
    blank_lead = 1'b0; colon_blink = 1'b0;
    repeat (3) @(negedge clk);
    compare("reset_state", 0, 4'hF, 7'h7F, 1'b1);
    exp("ff_blank1", 1, 4'hF, 7'h7F, 1'b1);
    exp("ff_blank2", 2, 4'hF, 7'h7F, 1'b1);
    exp("ff_s0_first", 3, 4'hE, 7'h19, 1'b1);
    exp("snap_hold6", 6, 4'hE, 7'h19, 1'b1);
    exp("snap_hold8", 8, 4'hE, 7'h19, 1'b1);
    exp("ff_s1_blank", 9, 4'hF, 7'h7F, 1'b1);
    exp("ff_s1_show", 11, 4'hD, 7'h30, 1'b1);
    exp("ff_s1_last", 16, 4'hD, 7'h30, 1'b1);
    exp("ff_s2_show", 19, 4'hB, 7'h24, 1'b0);
    exp("ff_s2_last", 24, 4'hB, 7'h24, 1'b0);
    exp("ff_s3_show", 27, 4'h7, 7'h79, 1'b1);
    exp("ff_s3_last", 32, 4'h7, 7'h79, 1'b1);
    exp("f2_blank", 33, 4'hF, 7'h7F, 1'b1);
    exp("f2_s0_new", 35, 4'hE, 7'h78, 1'b1);
    exp("f2_s0_last", 40, 4'hE, 7'h78, 1'b1);
    exp("f2_s2_show", 52, 4'hB, 7'h24, 1'b0);
    release_rst();
    run_until(5);
    min0 = 4'd7;
    run_until(52);
    rst = 1'b0;
    #1;
    compare("async_rst", edge_n, 4'hF, 7'h7F, 1'b1);
    drain("first_frame");

    // Restart after the mid-slot reset: timing must match a fresh first frame
    exp("rr_blank1", 1, 4'hF, 7'h7F, 1'b1);
    exp("rr_s0", 3, 4'hE, 7'h78, 1'b1);
    exp("rr_s1", 11, 4'hD, 7'h30, 1'b1);
    exp("rr_s2", 19, 4'hB, 7'h24, 1'b0);
    exp("rr_s3", 27, 4'h7, 7'h79, 1'b1);
    release_rst();
    run_until(28);
    drain("restart");
    do_reset();

    // Scenario: 09:59 with leading-zero suppression
    hour1 = 2'd0; hour0 = 4'd9; min1 = 3'd5; min0 = 4'd9; blank_lead = 1'b1;
    exp("lz_s0", 3, 4'hE, 7'h10, 1'b1);
    exp("lz_s1", 11, 4'hD, 7'h12, 1'b1);
    exp("lz_s2", 19, 4'hB, 7'h10, 1'b0);
    exp("lz_s3_blank", 27, 4'h7, 7'h7F, 1'b1);
    release_rst();
    run_until(28);
    drain("lead_zero");
    do_reset();

    // Scenario: 19:59 with leading-zero suppression enabled but nonzero tens
    hour1 = 2'd1;
    exp("lz_nz_s3", 27, 4'h7, 7'h79, 1'b1);
    release_rst();
    run_until(28);
    drain("lead_nonzero");
    do_reset();

    // Scenario: invalid BCD hours units shows a dash
    hour0 = 4'hC; blank_lead = 1'b0;
    exp("bad_bcd_s2", 19, 4'hB, 7'h3F, 1'b0);
    exp("bad_bcd_s3", 27, 4'h7, 7'h79, 1'b1);
    release_rst();
    run_until(28);
    drain("invalid_bcd");
    do_reset();

    // Scenario: blinking colon, 20-cycle half period
    hour1 = 2'd1; hour0 = 4'd2; min1 = 3'd3; min0 = 4'd4; colon_blink = 1'b1;
    exp("blink_19", 19, 4'hB, 7'h24, 1'b0);
    exp("blink_20", 20, 4'hB, 7'h24, 1'b0);
    exp("blink_21", 21, 4'hB, 7'h24, 1'b1);
    exp("blink_24", 24, 4'hB, 7'h24, 1'b1);
    exp("blink_s3", 27, 4'h7, 7'h79, 1'b1);
    exp("blink_51", 51, 4'hB, 7'h24, 1'b0);
    exp("blink_56", 56, 4'hB, 7'h24, 1'b0);
    exp("blink_83", 83, 4'hB, 7'h24, 1'b0);
    exp("blink_115", 115, 4'hB, 7'h24, 1'b1);
    exp("blink_120", 120, 4'hB, 7'h24, 1'b1);
    release_rst();
    run_until(121);
    drain("colon_blink");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
